// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg
// Shared definitions for the PLL lock supervisor: the FSM state encoding
// and the helper used to size its counters.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN,
        FAULT
    } pll_sup_state_t;

    // Width needed to hold the value 0..value.
    function automatic int cnt_width(input int value);
        return (value < 1) ? 1 : $clog2(value + 1);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Generic two-flop bit synchroniser for a single asynchronous level.
// Ports:
//   clk - destination clock
//   rst - synchronous active-high reset, clears both stages
//   d   - asynchronous input
//   q   - synchronised output, two clk cycles behind d
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic sync_p0;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            q       <= 1'b0;
        end else begin
            sync_p0 <= d;
            q       <= sync_p0;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
// Pulses the PLL reset, waits for a debounced lock within a timeout
// (retrying a bounded number of times), then releases the downstream
// domain resets one by one in index order. Loss of lock in RELEASE/RUN
// re-asserts every domain reset and restarts the whole sequence.
// Ports:
//   clkin1     - PLL reference clock
//   rst        - synchronous active-high reset
//   pll_lock   - raw PLL lock, asynchronous to clkin1
//   relock_req - single-cycle request to restart from any state
//   pll_rst    - PLL reset, active high
//   domain_rst - per-domain resets, active high
//   locked     - all domains released with a stable lock
//   fault      - lock retries exhausted
//   retry_cnt  - timeouts since the last successful release or relock
//   loss_cnt   - lock-loss events in RELEASE/RUN, saturating at 255
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int NUM_DOMAINS         = 2,
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int RELEASE_GAP_CYCLES  = 64,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                   clkin1,
    input  logic                   rst,
    input  logic                   pll_lock,
    input  logic                   relock_req,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] domain_rst,
    output logic                   locked,
    output logic                   fault,
    output logic [3:0]             retry_cnt,
    output logic [7:0]             loss_cnt
);

    // One counter is shared by every timed state, so it is sized for the
    // largest of the four intervals.
    localparam int CNT_W = max2(max2(cnt_width(RST_PULSE_CYCLES), cnt_width(LOCK_TIMEOUT_CYCLES)),
                                max2(cnt_width(LOCK_STABLE_CYCLES), cnt_width(RELEASE_GAP_CYCLES)));
    localparam int IDX_W = cnt_width(NUM_DOMAINS);

    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(RELEASE_GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);
    localparam logic [NUM_DOMAINS-1:0] ALL_RST = '1;

    logic           lock_s;
    pll_sup_state_t state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] rel_idx;

    sync_2ff u_lock_sync (
        .clk (clkin1),
        .rst (rst),
        .d   (pll_lock),
        .q   (lock_s)
    );

    // Outputs are written alongside each transition so that they always
    // reflect the state being entered on the same edge.
    always_ff @(posedge clkin1) begin
        if (rst) begin
            state      <= PLL_RST;
            cnt        <= '0;
            rel_idx    <= '0;
            pll_rst    <= 1'b1;
            domain_rst <= ALL_RST;
            locked     <= 1'b0;
            fault      <= 1'b0;
            retry_cnt  <= '0;
            loss_cnt   <= '0;
        end else if (relock_req) begin
            // A relock also swallows a simultaneous lock loss.
            state      <= PLL_RST;
            cnt        <= '0;
            pll_rst    <= 1'b1;
            domain_rst <= ALL_RST;
            locked     <= 1'b0;
            fault      <= 1'b0;
            retry_cnt  <= '0;
        end else if ((state == RELEASE || state == RUN) && !lock_s) begin
            state      <= PLL_RST;
            cnt        <= '0;
            pll_rst    <= 1'b1;
            domain_rst <= ALL_RST;
            locked     <= 1'b0;
            if (loss_cnt != 8'hFF) begin
                loss_cnt <= loss_cnt + 8'd1;
            end
        end else begin
            case (state)
                PLL_RST: begin
                    if (cnt == PULSE_LAST) begin
                        state   <= WAIT_LOCK;
                        cnt     <= '0;
                        pll_rst <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    // Lock is checked first so it wins over a same-cycle timeout.
                    if (lock_s) begin
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        cnt     <= '0;
                        pll_rst <= 1'b1;
                        if (retry_cnt == RETRY_MAX) begin
                            state      <= FAULT;
                            fault      <= 1'b1;
                            domain_rst <= ALL_RST;
                        end else begin
                            state     <= PLL_RST;
                            retry_cnt <= retry_cnt + 4'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        // Domain 0 is released on the edge that enters RELEASE.
                        cnt        <= '0;
                        domain_rst <= ALL_RST << 1;
                        if (NUM_DOMAINS == 1) begin
                            state     <= RUN;
                            locked    <= 1'b1;
                            retry_cnt <= '0;
                        end else begin
                            state   <= RELEASE;
                            rel_idx <= IDX_W'(1);
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (cnt == GAP_LAST) begin
                        cnt <= '0;
                        // Shifting a zero in from the bottom keeps release in index order.
                        domain_rst <= domain_rst << 1;
                        if (rel_idx == IDX_LAST) begin
                            state     <= RUN;
                            locked    <= 1'b1;
                            retry_cnt <= '0;
                        end else begin
                            rel_idx <= rel_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    retry_cnt <= '0;
                end
                FAULT: begin
                    pll_rst    <= 1'b1;
                    fault      <= 1'b1;
                    domain_rst <= ALL_RST;
                end
                default: begin
                    state      <= PLL_RST;
                    cnt        <= '0;
                    pll_rst    <= 1'b1;
                    domain_rst <= ALL_RST;
                    locked     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor
// Directed bench for pll_lock_supervisor with NUM_DOMAINS=3,
// RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=100, LOCK_STABLE_CYCLES=16,
// RELEASE_GAP_CYCLES=8, MAX_RETRIES=2. Cycle 0 is the first cycle after
// the last reset edge; inputs change and outputs are sampled 1 time unit
// after each rising edge.
module tb_pll_lock_supervisor;

    logic       clkin1 = 1'b0;
    logic       rst = 1'b1;
    logic       pll_lock = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst;
    logic [2:0] domain_rst;
    logic       locked;
    logic       fault;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    pll_lock_supervisor #(
        .NUM_DOMAINS         (3),
        .RST_PULSE_CYCLES    (4),
        .LOCK_TIMEOUT_CYCLES (100),
        .LOCK_STABLE_CYCLES  (16),
        .RELEASE_GAP_CYCLES  (8),
        .MAX_RETRIES         (2)
    ) dut (
        .clkin1     (clkin1),
        .rst        (rst),
        .pll_lock   (pll_lock),
        .relock_req (relock_req),
        .pll_rst    (pll_rst),
        .domain_rst (domain_rst),
        .locked     (locked),
        .fault      (fault),
        .retry_cnt  (retry_cnt),
        .loss_cnt   (loss_cnt)
    );

    always #5 clkin1 = ~clkin1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clkin1);
            #1;
            cyc++;
        end
    endtask

    // Two reset edges; on return the bench sits in cycle 0 with rst low.
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clkin1);
        #1;
        @(posedge clkin1);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_pll_rst"}, 32'(pll_rst), 1);
        chk({tag, "_domain_rst"}, 32'(domain_rst), 7);
        chk({tag, "_locked"}, 32'(locked), 0);
        chk({tag, "_fault"}, 32'(fault), 0);
        chk({tag, "_retry_cnt"}, 32'(retry_cnt), 0);
        chk({tag, "_loss_cnt"}, 32'(loss_cnt), 0);
    endtask

    initial begin
        // Normal lock
        pll_lock = 1'b0;
        do_reset();
        chk_reset_values("reset");
        goto(3);   chk("pulse_end_hi", 32'(pll_rst), 1);
        goto(4);   chk("pulse_done", 32'(pll_rst), 0);
        goto(20);  pll_lock = 1'b1;
        goto(38);  chk("pre_release", 32'(domain_rst), 7);
        goto(39);  chk("release0", 32'(domain_rst), 6);
        goto(46);  chk("hold0", 32'(domain_rst), 6);
        goto(47);  chk("release1", 32'(domain_rst), 4);
        goto(54);  chk("pre_release2", 32'(domain_rst), 4);
                   chk("pre_locked", 32'(locked), 0);
        goto(55);  chk("release2", 32'(domain_rst), 0);
                   chk("locked_rise", 32'(locked), 1);
                   chk("run_retry", 32'(retry_cnt), 0);

        // Loss in RUN
        goto(60);  pll_lock = 1'b0;
        goto(62);  chk("loss_pre_dom", 32'(domain_rst), 0);
                   chk("loss_pre_locked", 32'(locked), 1);
        goto(63);  chk("loss_dom", 32'(domain_rst), 7);
                   chk("loss_locked", 32'(locked), 0);
                   chk("loss_cnt_1", 32'(loss_cnt), 1);
                   chk("loss_pll_rst", 32'(pll_rst), 1);
        goto(66);  chk("loss_pulse_end", 32'(pll_rst), 1);
        goto(67);  chk("loss_pulse_done", 32'(pll_rst), 0);
        goto(70);  pll_lock = 1'b1;
        goto(88);  chk("reseq_pre", 32'(domain_rst), 7);
        goto(89);  chk("reseq_rel0", 32'(domain_rst), 6);
        goto(105); chk("reseq_dom", 32'(domain_rst), 0);
                   chk("reseq_locked", 32'(locked), 1);
                   chk("reseq_loss", 32'(loss_cnt), 1);

        // Relock together with lock loss: counts only as relock
        goto(110); pll_lock = 1'b0;
        goto(112); relock_req = 1'b1;
        goto(113); relock_req = 1'b0;
                   chk("relock_loss_cnt", 32'(loss_cnt), 1);
                   chk("relock_loss_dom", 32'(domain_rst), 7);
                   chk("relock_loss_pll", 32'(pll_rst), 1);
                   chk("relock_loss_locked", 32'(locked), 0);

        // Lock glitch
        pll_lock = 1'b0;
        do_reset();
        goto(20);  pll_lock = 1'b1;
        goto(30);  pll_lock = 1'b0;
        goto(31);  pll_lock = 1'b1;
        goto(39);  chk("glitch_no_early", 32'(domain_rst), 7);
        goto(49);  chk("glitch_pre", 32'(domain_rst), 7);
        goto(50);  chk("glitch_rel0", 32'(domain_rst), 6);
                   chk("glitch_loss", 32'(loss_cnt), 0);

        // Timeout and fault
        pll_lock = 1'b0;
        do_reset();
        goto(103); chk("to1_pre", 32'(pll_rst), 0);
                   chk("to1_pre_retry", 32'(retry_cnt), 0);
        goto(104); chk("to1_pulse", 32'(pll_rst), 1);
                   chk("to1_retry", 32'(retry_cnt), 1);
        goto(107); chk("to1_pulse_end", 32'(pll_rst), 1);
        goto(108); chk("to1_pulse_done", 32'(pll_rst), 0);
        goto(207); chk("to2_pre", 32'(pll_rst), 0);
        goto(208); chk("to2_pulse", 32'(pll_rst), 1);
                   chk("to2_retry", 32'(retry_cnt), 2);
        goto(311); chk("to3_pre_fault", 32'(fault), 0);
        goto(312); chk("fault_set", 32'(fault), 1);
                   chk("fault_retry", 32'(retry_cnt), 2);
                   chk("fault_dom", 32'(domain_rst), 7);
                   chk("fault_pll", 32'(pll_rst), 1);
        goto(320); chk("fault_hold", 32'(fault), 1);

        // Relock from FAULT
        relock_req = 1'b1;
        goto(321); relock_req = 1'b0;
                   chk("relock_fault", 32'(fault), 0);
                   chk("relock_retry", 32'(retry_cnt), 0);
                   chk("relock_pll", 32'(pll_rst), 1);
        goto(324); chk("relock_pulse_end", 32'(pll_rst), 1);
        goto(325); chk("relock_pulse_done", 32'(pll_rst), 0);

        // Timeout coinciding with lock_s rising: lock wins
        pll_lock = 1'b0;
        do_reset();
        goto(101); pll_lock = 1'b1;
        goto(104); chk("race_pll", 32'(pll_rst), 0);
                   chk("race_retry", 32'(retry_cnt), 0);
        goto(119); chk("race_pre_rel", 32'(domain_rst), 7);
        goto(120); chk("race_rel0", 32'(domain_rst), 6);

        // Reset mid-RELEASE
        goto(121); rst = 1'b1;
        goto(122); chk_reset_values("midrel");
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
